psum_spad_acc: RTL and testbench

Parametrised partial-sum scratchpad for the PE datapath. Adds over the plain scratchpad:
- a pipelined read-modify-write accumulate port with hazard forwarding;
- optional signed saturation;
- a read-valid strobe;
- a self-sequencing clear engine that zeroes the whole array between output tiles.

Sits between the PE MAC and the psum in/out paths.

---
 rtl/psum_spad_acc.sv | 156 +++++++++++++++
 tb/tb_psum_spad_acc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_spad_acc.sv
// Partial-sum scratchpad: registered read, 3-stage read-modify-write accumulate with forwarding, clear engine.
// Read latency 1; accumulate writeback 2 cycles after acceptance; acc_ready drops while a clear is pending or running.
module psum_spad_acc #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 5,
    parameter int SATURATE      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_req,
    input  logic [ADDR_BITWIDTH-1:0] r_addr,
    output logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     r_valid,
    input  logic                     write_en,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     acc_en,
    input  logic [ADDR_BITWIDTH-1:0] acc_addr,
    input  logic [DATA_BITWIDTH-1:0] acc_data,
    output logic                     acc_ready,
    output logic                     w_conflict,
    input  logic                     clear_start,
    output logic                     clear_busy
);
    localparam int DEPTH = 1 << ADDR_BITWIDTH;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t                     state, state_nxt;
    logic [ADDR_BITWIDTH-1:0]   cnt, cnt_nxt;
    logic [DATA_BITWIDTH-1:0]   mem [DEPTH];

    logic                       s1_vld, s2_vld;
    logic [ADDR_BITWIDTH-1:0]   s1_addr, s2_addr;
    logic [DATA_BITWIDTH-1:0]   s1_data, s2_data, s2_op;

    logic                       acc_fire, wr_plain;
    logic [DATA_BITWIDTH:0]     sum_wide;
    logic [DATA_BITWIDTH-1:0]   sum, op_fwd;
    logic                       mem_we;
    logic [ADDR_BITWIDTH-1:0]   mem_wa;
    logic [DATA_BITWIDTH-1:0]   mem_wd;

    assign clear_busy = (state != IDLE);
    assign acc_ready  = (state == IDLE) && !clear_start;
    assign acc_fire   = acc_en && acc_ready;
    // A plain write only commits when neither the clear engine nor a writeback owns the port.
    assign wr_plain   = write_en && !s2_vld && !clear_busy;

    assign sum_wide = {s2_op[DATA_BITWIDTH-1], s2_op} + {s2_data[DATA_BITWIDTH-1], s2_data};

    always_comb begin
        sum = sum_wide[DATA_BITWIDTH-1:0];
        if (SATURATE != 0 && sum_wide[DATA_BITWIDTH] != sum_wide[DATA_BITWIDTH-1]) begin
            sum = sum_wide[DATA_BITWIDTH] ? {1'b1, {(DATA_BITWIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
        end
    end

    // Operand fetch sees whatever commits to the same address this cycle.
    always_comb begin
        op_fwd = mem[s1_addr];
        if (s2_vld && s2_addr == s1_addr) begin
            op_fwd = sum;
        end else if (wr_plain && w_addr == s1_addr) begin
            op_fwd = w_data;
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = cnt;
            end else if (s2_vld) begin
                mem_we = 1'b1;
                mem_wa = s2_addr;
                mem_wd = sum;
            end else if (wr_plain) begin
                mem_we = 1'b1;
                mem_wa = w_addr;
                mem_wd = w_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_nxt = (s1_vld || s2_vld) ? DRAIN : CLEAR;
                end
            end
            DRAIN: begin
                if (!s1_vld && !s2_vld) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_BITWIDTH{1'b1}}) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s1_addr    <= '0;
            s1_data    <= '0;
            s2_addr    <= '0;
            s2_data    <= '0;
            s2_op      <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            w_conflict <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            s1_vld     <= acc_fire;
            s2_vld     <= s1_vld;
            r_valid    <= read_req;
            w_conflict <= write_en && (s2_vld || clear_busy);
            if (acc_fire) begin
                s1_addr <= acc_addr;
                s1_data <= acc_data;
            end
            if (s1_vld) begin
                s2_addr <= s1_addr;
                s2_data <= s1_data;
                s2_op   <= op_fwd;
            end
            if (read_req) begin
                r_data <= mem[r_addr];
            end
        end
    end
endmodule

// File: tb/tb_psum_spad_acc.sv
// Directed bench for psum_spad_acc: wrapping and saturating instances, read data checked by a queue-based monitor.
module tb_psum_spad_acc;
    logic        clk = 1'b0;
    logic        reset;
    logic        read_req, read_req_s, write_en, write_en_s, acc_en, acc_en_s, clear_start;
    logic [4:0]  r_addr, w_addr, acc_addr;
    logic [15:0] w_data, acc_data;
    logic [15:0] r_data, r_data_s;
    logic        r_valid, r_valid_s, acc_ready, acc_ready_s;
    logic        w_conflict, w_conflict_s, clear_busy, clear_busy_s;

    int          checks = 0;
    int          failures = 0;
    logic        sel = 1'b0;
    logic [15:0] q[$];
    logic [15:0] q_s[$];
    logic [4:0]  qa[$];
    logic [4:0]  qa_s[$];

    always #5 clk = ~clk;

    psum_spad_acc #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(5), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .read_req(read_req), .r_addr(r_addr), .r_data(r_data),
        .r_valid(r_valid), .write_en(write_en), .w_addr(w_addr), .w_data(w_data),
        .acc_en(acc_en), .acc_addr(acc_addr), .acc_data(acc_data), .acc_ready(acc_ready),
        .w_conflict(w_conflict), .clear_start(clear_start), .clear_busy(clear_busy));

    psum_spad_acc #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(5), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .read_req(read_req_s), .r_addr(r_addr), .r_data(r_data_s),
        .r_valid(r_valid_s), .write_en(write_en_s), .w_addr(w_addr), .w_data(w_data),
        .acc_en(acc_en_s), .acc_addr(acc_addr), .acc_data(acc_data), .acc_ready(acc_ready_s),
        .w_conflict(w_conflict_s), .clear_start(1'b0), .clear_busy(clear_busy_s));

    // Read-response monitors
    always @(negedge clk) begin
        if (r_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: r_valid=1 with no read outstanding, r_data=%h", r_data);
            end else begin
                logic [15:0] e;
                logic [4:0]  a;
                e = q.pop_front();
                a = qa.pop_front();
                if (r_data !== e) begin
                    failures++;
                    $display("FAIL rd_wrap[%0d]: got %h expected %h", a, r_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (r_valid_s) begin
            checks++;
            if (q_s.size() == 0) begin
                failures++;
                $display("FAIL rd_sat_unexpected: r_valid=1 with no read outstanding, r_data=%h", r_data_s);
            end else begin
                logic [15:0] e;
                logic [4:0]  a;
                e = q_s.pop_front();
                a = qa_s.pop_front();
                if (r_data_s !== e) begin
                    failures++;
                    $display("FAIL rd_sat[%0d]: got %h expected %h", a, r_data_s, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        w_addr = a;
        w_data = d;
        if (sel) write_en_s = 1'b1; else write_en = 1'b1;
        tick();
        write_en   = 1'b0;
        write_en_s = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] e);
        r_addr = a;
        if (sel) begin
            read_req_s = 1'b1;
            q_s.push_back(e);
            qa_s.push_back(a);
        end else begin
            read_req = 1'b1;
            q.push_back(e);
            qa.push_back(a);
        end
        tick();
        read_req   = 1'b0;
        read_req_s = 1'b0;
    endtask

    task automatic acc(input logic [4:0] a, input logic [15:0] d);
        acc_addr = a;
        acc_data = d;
        if (sel) acc_en_s = 1'b1; else acc_en = 1'b1;
        tick();
        acc_en   = 1'b0;
        acc_en_s = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        read_req = 1'b0; read_req_s = 1'b0; write_en = 1'b0; write_en_s = 1'b0;
        acc_en = 1'b0; acc_en_s = 1'b0; clear_start = 1'b0;
        r_addr = '0; w_addr = '0; w_data = '0; acc_addr = '0; acc_data = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_r_data", r_data, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_w_conflict", w_conflict, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_acc_ready_sat", acc_ready_s, 1);

        // 1: write then read, r_data holds when idle
        wr(3, 16'd100);
        chk("wr_no_conflict", w_conflict, 0);
        rd(3, 16'd100);
        chk("rd_valid_hi", r_valid, 1);
        tick();
        chk("rd_valid_lo", r_valid, 0);
        chk("rd_data_hold", r_data, 16'd100);

        // 2: back-to-back accumulates, intermediate values via read-before-write
        wr(5, 16'd10);
        chk("acc_ready_idle", acc_ready, 1);
        acc(5, 16'd1);
        acc(5, 16'd2);
        acc(5, 16'd3);
        rd(5, 16'd11);
        rd(5, 16'd13);
        rd(5, 16'd16);

        // 3: saturation and wrap
        sel = 1'b1;
        wr(7, 16'd32760);
        acc(7, 16'd100);
        tick(); tick();
        rd(7, 16'h7FFF);
        wr(8, 16'h8008);
        acc(8, 16'hFF9C);
        tick(); tick();
        rd(8, 16'h8000);
        wr(10, 16'd50);
        acc(10, 16'hFFF6);
        tick(); tick();
        rd(10, 16'd40);
        sel = 1'b0;
        wr(7, 16'd32760);
        acc(7, 16'd100);
        tick(); tick();
        rd(7, 16'h805C);

        // 4: plain write collides with writeback
        wr(9, 16'h0909);
        wr(2, 16'd20);
        acc(2, 16'd5);
        tick();
        wr(9, 16'hBEEF);
        chk("conflict_pulse", w_conflict, 1);
        tick();
        chk("conflict_clear", w_conflict, 0);
        rd(2, 16'd25);
        rd(9, 16'h0909);

        // 5: fill, accumulate, clear with drain
        for (int i = 0; i < 32; i++) wr(5'(i), 16'(i * 3 + 1));
        acc(4, 16'd1);
        acc(6, 16'd2);
        clear_start = 1'b1;
        #1;
        chk("acc_ready_on_start", acc_ready, 0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        n = 0;
        while (clear_busy && n < 100) begin
            chk("acc_ready_busy", acc_ready, 0);
            if (n == 0) begin
                w_addr = 5'd31; w_data = 16'h7777; write_en = 1'b1;
            end else begin
                write_en = 1'b0;
            end
            if (n == 1) chk("conflict_busy", w_conflict, 1);
            n++;
            tick();
        end
        write_en = 1'b0;
        chk("busy_cycles", n, 34);
        chk("acc_ready_after_clear", acc_ready, 1);
        for (int i = 0; i < 32; i++) rd(5'(i), 16'd0);

        // 6: reset during clear
        for (int i = 0; i < 32; i++) wr(5'(i), 16'(i + 16'h100));
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (10) tick();
        chk("busy_before_reset", clear_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", clear_busy, 0);
        chk("rst_mid_acc_ready", acc_ready, 1);
        for (int i = 0; i < 10; i++) rd(5'(i), 16'd0);
        for (int i = 11; i < 32; i++) rd(5'(i), 16'(i + 16'h100));

        tick(); tick();
        chk("reads_outstanding", q.size() + q_s.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
